// File: rtl/alu_muldiv_pkg.sv
// Shared constants for the multi-cycle unsigned multiply/divide unit.
// Holds the operation codes, FSM state encoding and the divide-by-zero test.
package alu_muldiv_pkg;

  localparam logic MULDIV_OP_MUL = 1'b0;
  localparam logic MULDIV_OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    MULDIV_ST_IDLE = 2'd0,
    MULDIV_ST_RUN  = 2'd1,
    MULDIV_ST_FIN  = 2'd2
  } muldiv_state_e;

  // A zero divisor short-circuits straight to completion.
  function automatic logic is_div_by_zero(input logic op, input logic zero_b);
    return (op == MULDIV_OP_DIV) && zero_b;
  endfunction

endpackage

// File: rtl/alu_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// MUL: acc is the running high half, shreg holds the multiplier (LSB first).
// DIV: acc is the partial remainder, shreg holds the dividend then the quotient.
module alu_muldiv_step
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] shreg,
  input  logic [WIDTH-1:0] opnd,
  input  logic             op,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] shreg_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum        = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : {(WIDTH + 1){1'b0}});
    shifted    = {acc, shreg[WIDTH-1]};
    // Remainder after a successful subtract is below the divisor, so WIDTH bits suffice.
    diff       = shifted[WIDTH-1:0] - opnd;
    acc_next   = sum[WIDTH:1];
    shreg_next = {sum[0], shreg[WIDTH-1:1]};
    if (op == MULDIV_OP_DIV) begin
      if (shifted >= {1'b0, opnd}) begin
        acc_next   = diff;
        shreg_next = {shreg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next   = shifted[WIDTH-1:0];
        shreg_next = {shreg[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle unsigned multiply/divide unit with a START/BUSY/DONE handshake.
// One iteration per clock; double-width result returned through RESULT_HI/RESULT_LO.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] ALUA_DATA,
  input  logic [WIDTH-1:0] ALUB_DATA,
  input  logic             OP,
  input  logic             START,
  input  logic             ABORT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT_LO,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic             DIV0
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  muldiv_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] opnd;
  logic             op_q;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             div0;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] shreg_next;

  alu_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc       (acc),
    .shreg     (shreg),
    .opnd      (opnd),
    .op        (op_q),
    .acc_next  (acc_next),
    .shreg_next(shreg_next)
  );

  // Sequencer: operand capture, iteration, result capture and handshake flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= MULDIV_ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      shreg  <= '0;
      opnd   <= '0;
      op_q   <= MULDIV_OP_MUL;
      busy   <= 1'b0;
      done   <= 1'b0;
      res_lo <= '0;
      res_hi <= '0;
      div0   <= 1'b0;
    end else begin
      case (state)
        MULDIV_ST_RUN: begin
          // ABORT wins over everything; START is ignored while running.
          if (ABORT) begin
            state <= MULDIV_ST_IDLE;
            busy  <= 1'b0;
          end else begin
            acc   <= acc_next;
            shreg <= shreg_next;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST_ITER) begin
              state  <= MULDIV_ST_FIN;
              busy   <= 1'b0;
              done   <= 1'b1;
              res_lo <= shreg_next;
              res_hi <= acc_next;
              div0   <= 1'b0;
            end
          end
        end
        default: begin
          // IDLE and FIN both accept a new request; FIN otherwise falls back to IDLE.
          state <= MULDIV_ST_IDLE;
          done  <= 1'b0;
          if (START) begin
            op_q <= OP;
            acc  <= '0;
            cnt  <= '0;
            if (OP == MULDIV_OP_DIV) begin
              shreg <= ALUA_DATA;
              opnd  <= ALUB_DATA;
            end else begin
              shreg <= ALUB_DATA;
              opnd  <= ALUA_DATA;
            end
            if (is_div_by_zero(OP, ALUB_DATA == '0)) begin
              state  <= MULDIV_ST_FIN;
              done   <= 1'b1;
              res_lo <= '1;
              res_hi <= ALUA_DATA;
              div0   <= 1'b1;
            end else begin
              state <= MULDIV_ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign BUSY      = busy;
  assign DONE      = done;
  assign RESULT_LO = res_lo;
  assign RESULT_HI = res_hi;
  assign DIV0      = div0;

endmodule
